instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Inverse of the main control decoder. Accepts symbolic instructions (class, registers,
//  immediate, ALU function), encodes them as RV64I words, and streams them into the
//  instruction-memory write port at consecutive word addresses.
//  Used by the bench and boot path to load programs into instruction memory before the
//  datapath runs.
// PARAMETERS
//  ADDR_W     10   byte-address width of the imem write port
//  BASE_ADDR  0    byte address of the first word written
//  DEPTH      256  max words per load session; BASE_ADDR+4*DEPTH <= 2**ADDR_W
// PORTS
//  clk_i        in   1       clock, rising edge
//  rst_i        in   1       asynchronous, active-low reset
//  start_i      in   1       open a load session (IDLE/DONE only)
//  finish_i     in   1       close the session early
//  req_valid_i  in   1       instruction request valid
//  req_ready_o  out  1       block can accept a request
//  req_class_i  in   3       0=R 1=ld 2=sd 3=beq 4=addi 5=slti; 6,7 illegal
//  alu_fn_i     in   4       R-type {funct7[5],funct3}
//  rd_i         in   5       destination reg
//  rs1_i        in   5       source reg 1
//  rs2_i        in   5       source reg 2
//  imm_i        in   13      immediate; I/S types use [11:0]; beq uses [12:1], bit0 ignored
//  we_o         out  1       imem write strobe
//  waddr_o      out  ADDR_W  imem byte address
//  wdata_o      out  32      encoded instruction word
//  count_o      out  $clog2(DEPTH+1)  words written this session
//  done_o       out  1       session closed
//  err_o        out  1       sticky: illegal class seen this session
// BEHAVIOUR
//  Reset (rst_i=0, async): state=IDLE, we_o=0, waddr_o=BASE_ADDR, wdata_o=0,
//    count_o=0, done_o=0, err_o=0, req_ready_o=0.
//  FSM states: IDLE, LOAD, DONE.
//  - IDLE/DONE + start_i -> LOAD. Clears count_o and err_o; pointer=BASE_ADDR; done_o=0.
//  - LOAD: req_ready_o=1 combinationally, while count_o<DEPTH.
//    Handshake = req_valid_i & req_ready_o.
//  - LOAD + finish_i -> DONE. A handshake in the same cycle is still honoured (written).
//  - LOAD + handshake bringing count_o to DEPTH -> DONE. req_ready_o=0 from the next cycle.
//  - DONE: done_o=1, req_ready_o=0. Holds until start_i.
//  Write timing: legal handshake in cycle N -> we_o=1 in cycle N+1 for exactly one cycle.
//    waddr_o = pointer at handshake; wdata_o = encoded word.
//    Pointer += 4 and count_o += 1, both visible in N+1.
//  Throughput: one handshake per cycle; back-to-back writes with no gaps.
//  wdata_o/waddr_o hold their last values when we_o=0.
//  Illegal class (6,7): handshake completes; no write, no pointer/count change; err_o<=1.
//  Requests outside LOAD are not accepted (ready low); inputs are ignored.
//  Encoding (op = opcode):
//    R    {fn[3]?7'h20:7'h00, rs2, rs1, fn[2:0], rd, 7'b0110011}
//    ld   {imm[11:0], rs1, 3'b011, rd, 7'b0000011}
//    sd   {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011}
//    beq  {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011}
//    addi {imm[11:0], rs1, 3'b000, rd, 7'b0010011}; slti same with funct3=3'b010
//  Round-trip property: wdata_o[6:0], fed to the main control decoder, yields that
//    class's control set (e.g. ld -> RegWrite=1, MemRead=1, MemtoReg=1).
//  Reset mid-session: abandons the session immediately. A pending write is dropped.
// TESTING
//  1. start_i, then {R, fn=0, rd=3, rs1=1, rs2=2} -> next cycle we_o=1, waddr=0,
//     wdata=0x002081B3; fn=4'b1000 -> wdata=0x402081B3 at waddr=4.
//  2. ld x5,8(x2) -> 0x00813283; sd x5,16(x2) -> 0x00513823;
//     beq x1,x2,imm=-8 -> 0xFE208CE3; addi x1,x0,-1 -> 0xFFF00093.
//  3. DEPTH=4, five back-to-back valids -> four writes (addr 0,4,8,12) on consecutive
//     cycles; 5th not accepted; done_o=1, count_o=4.
//  4. class=7 between two legal requests -> err_o=1 sticky; legal words land at addr 0,4.
//     Next start_i clears err_o.
//  5. finish_i together with a handshake -> that word is written; then DONE, req_ready_o=0.
//  6. rst_i low the cycle after a handshake -> no we_o pulse; all outputs at reset values.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
// Request and imem-write bundle for instr_encoder_loader.
//  slave  : the loader (takes requests, drives ready and the imem write port)
//  master : whoever feeds symbolic instructions and observes the write port
//  Request : req_valid_i, req_ready_o, req_class_i, alu_fn_i, rd_i, rs1_i, rs2_i, imm_i
//  Write   : we_o, waddr_o, wdata_o
interface instr_encoder_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [2:0]        req_class_i;
  logic [3:0]        alu_fn_i;
  logic [4:0]        rd_i;
  logic [4:0]        rs1_i;
  logic [4:0]        rs2_i;
  logic [12:0]       imm_i;
  logic              we_o;
  logic [ADDR_W-1:0] waddr_o;
  logic [31:0]       wdata_o;

  modport slave (
    input  req_valid_i, req_class_i, alu_fn_i, rd_i, rs1_i, rs2_i, imm_i,
    output req_ready_o, we_o, waddr_o, wdata_o
  );

  modport master (
    output req_valid_i, req_class_i, alu_fn_i, rd_i, rs1_i, rs2_i, imm_i,
    input  req_ready_o, we_o, waddr_o, wdata_o
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic instructions (class, regs, immediate, ALU function) into RV64I words
// and streams them into the instruction-memory write port at consecutive word addresses.
//  clk_i     : clock, rising edge
//  rst_i     : asynchronous active-low reset
//  start_i   : open a load session (accepted in IDLE/DONE)
//  finish_i  : close the session early
//  bus       : request channel and imem write port (see instr_encoder_loader_if)
//  count_o   : words written this session
//  done_o    : session closed
//  err_o     : sticky, illegal class seen this session
module instr_encoder_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned DEPTH     = 256,
  localparam int unsigned CntW     = $clog2(DEPTH + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         finish_i,
  instr_encoder_loader_if.slave        bus,
  output logic [CntW-1:0]              count_o,
  output logic                         done_o,
  output logic                         err_o
);

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [CntW-1:0]   DepthCnt = CntW'(DEPTH);
  localparam logic [CntW-1:0]   LastCnt  = CntW'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e            stateQ, stateD;
  logic              weQ, weD;
  logic [ADDR_W-1:0] waddrQ, waddrD;
  logic [31:0]       wdataQ, wdataD;
  logic [ADDR_W-1:0] ptrQ, ptrD;
  logic [CntW-1:0]   countQ, countD;
  logic              errQ, errD;

  logic        reqReady;
  logic        handshake;
  logic        legalClass;
  logic        startOk;
  logic [31:0] encWord;

  // Encoder: symbolic request -> RV64I word
  always_comb begin
    logic [12:0] imm;
    imm     = bus.imm_i;
    encWord = 32'h0;
    unique case (bus.req_class_i)
      3'd0: encWord = {bus.alu_fn_i[3] ? 7'h20 : 7'h00, bus.rs2_i, bus.rs1_i,
                       bus.alu_fn_i[2:0], bus.rd_i, 7'b0110011};
      3'd1: encWord = {imm[11:0], bus.rs1_i, 3'b011, bus.rd_i, 7'b0000011};
      3'd2: encWord = {imm[11:5], bus.rs2_i, bus.rs1_i, 3'b011, imm[4:0], 7'b0100011};
      3'd3: encWord = {imm[12], imm[10:5], bus.rs2_i, bus.rs1_i, 3'b000, imm[4:1], imm[11],
                       7'b1100011};
      3'd4: encWord = {imm[11:0], bus.rs1_i, 3'b000, bus.rd_i, 7'b0010011};
      3'd5: encWord = {imm[11:0], bus.rs1_i, 3'b010, bus.rd_i, 7'b0010011};
      default: encWord = 32'h0;
    endcase
  end

  assign legalClass = (bus.req_class_i <= 3'd5);
  assign handshake  = bus.req_valid_i & reqReady;
  assign startOk    = start_i & (stateQ != StLoad);

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // FSM: next state
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: if (start_i) stateD = StLoad;
      StLoad: begin
        // An illegal request never advances the count, so it cannot close the session
        if (finish_i || (handshake && legalClass && (countQ == LastCnt))) stateD = StDone;
      end
      StDone: if (start_i) stateD = StLoad;
      default: stateD = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    reqReady = 1'b0;
    done_o   = 1'b0;
    unique case (stateQ)
      StLoad:  reqReady = (countQ < DepthCnt);
      StDone:  done_o   = 1'b1;
      default: ;
    endcase
  end

  // Datapath next state
  always_comb begin
    weD    = 1'b0;
    waddrD = waddrQ;
    wdataD = wdataQ;
    ptrD   = ptrQ;
    countD = countQ;
    errD   = errQ;
    if (startOk) begin
      ptrD   = BaseAddr;
      countD = '0;
      errD   = 1'b0;
    end else if (handshake) begin
      if (legalClass) begin
        weD    = 1'b1;
        waddrD = ptrQ;
        wdataD = encWord;
        ptrD   = ptrQ + ADDR_W'(4);
        countD = countQ + CntW'(1);
      end else begin
        errD = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      weQ    <= 1'b0;
      waddrQ <= BaseAddr;
      wdataQ <= 32'h0;
      ptrQ   <= BaseAddr;
      countQ <= '0;
      errQ   <= 1'b0;
    end else begin
      weQ    <= weD;
      waddrQ <= waddrD;
      wdataQ <= wdataD;
      ptrQ   <= ptrD;
      countQ <= countD;
      errQ   <= errD;
    end
  end

  assign bus.req_ready_o = reqReady;
  assign bus.we_o        = weQ;
  assign bus.waddr_o     = waddrQ;
  assign bus.wdata_o     = wdataQ;
  assign count_o         = countQ;
  assign err_o           = errQ;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

  localparam int unsigned AddrW = 10;
  localparam int unsigned Depth = 4;
  localparam int unsigned CntW  = $clog2(Depth + 1);

  logic            clk;
  logic            rstN;
  logic            start;
  logic            finish;
  logic [CntW-1:0] count;
  logic            done;
  logic            err;

  instr_encoder_loader_if #(.ADDR_W(AddrW)) bus ();

  instr_encoder_loader #(
    .ADDR_W   (AddrW),
    .BASE_ADDR(0),
    .DEPTH    (Depth)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rstN),
    .start_i (start),
    .finish_i(finish),
    .bus     (bus),
    .count_o (count),
    .done_o  (done),
    .err_o   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AddrW-1:0] addr;
    logic [31:0]      data;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nErrors = 0;
  int   streak = 0;
  int   maxStreak = 0;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] want);
    nChecks++;
    if (got !== want) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  // Scoreboard: every write pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (rstN && bus.we_o) begin
      if (expQ.size() == 0) begin
        checkEq("spurious_we", 64'(bus.we_o), 64'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkEq("waddr", 64'(bus.waddr_o), 64'(e.addr));
        checkEq("wdata", 64'(bus.wdata_o), 64'(e.data));
      end
      streak++;
      if (streak > maxStreak) maxStreak = streak;
    end else begin
      streak = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic [AddrW-1:0] addr, input logic [31:0] data);
    exp_t e;
    e.addr = addr;
    e.data = data;
    expQ.push_back(e);
  endtask

  task automatic setReq(input logic [2:0] cls, input logic [3:0] fn, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
    bus.req_class_i = cls;
    bus.alu_fn_i    = fn;
    bus.rd_i        = rd;
    bus.rs1_i       = rs1;
    bus.rs2_i       = rs2;
    bus.imm_i       = imm;
  endtask

  task automatic sendReq(input logic [2:0] cls, input logic [3:0] fn, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
    setReq(cls, fn, rd, rs1, rs2, imm);
    bus.req_valid_i = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulseFinish();
    finish = 1'b1;
    tick();
    finish = 1'b0;
  endtask

  initial begin
    rstN   = 1'b0;
    start  = 1'b0;
    finish = 1'b0;
    bus.req_valid_i = 1'b0;
    setReq(3'd0, 4'd0, 5'd0, 5'd0, 5'd0, 13'd0);
    repeat (3) @(posedge clk);
    #1;
    checkEq("rst_we", 64'(bus.we_o), 64'd0);
    checkEq("rst_waddr", 64'(bus.waddr_o), 64'd0);
    checkEq("rst_wdata", 64'(bus.wdata_o), 64'd0);
    checkEq("rst_count", 64'(count), 64'd0);
    checkEq("rst_done", 64'(done), 64'd0);
    checkEq("rst_err", 64'(err), 64'd0);
    checkEq("rst_ready", 64'(bus.req_ready_o), 64'd0);
    rstN = 1'b1;
    tick();
    checkEq("idle_ready", 64'(bus.req_ready_o), 64'd0);

    // R-type words
    pulseStart();
    checkEq("load_ready", 64'(bus.req_ready_o), 64'd1);
    pushExp(10'd0, 32'h002081B3);
    sendReq(3'd0, 4'b0000, 5'd3, 5'd1, 5'd2, 13'd0);
    checkEq("count_after1", 64'(count), 64'd1);
    pushExp(10'd4, 32'h402081B3);
    sendReq(3'd0, 4'b1000, 5'd3, 5'd1, 5'd2, 13'd0);
    tick();
    checkEq("wdata_hold", 64'(bus.wdata_o), 64'h402081B3);
    pulseFinish();
    checkEq("t1_done", 64'(done), 64'd1);
    checkEq("t1_ready", 64'(bus.req_ready_o), 64'd0);
    checkEq("t1_count", 64'(count), 64'd2);

    // Other classes; fourth word fills the session
    pulseStart();
    checkEq("restart_count", 64'(count), 64'd0);
    checkEq("restart_done", 64'(done), 64'd0);
    pushExp(10'd0, 32'h00813283);
    sendReq(3'd1, 4'd0, 5'd5, 5'd2, 5'd0, 13'd8);
    pushExp(10'd4, 32'h00513823);
    sendReq(3'd2, 4'd0, 5'd0, 5'd2, 5'd5, 13'd16);
    pushExp(10'd8, 32'hFE208CE3);
    sendReq(3'd3, 4'd0, 5'd0, 5'd1, 5'd2, 13'h1FF8);
    pushExp(10'd12, 32'hFFF00093);
    sendReq(3'd4, 4'd0, 5'd1, 5'd0, 5'd0, 13'h1FFF);
    checkEq("t2_done", 64'(done), 64'd1);
    checkEq("t2_count", 64'(count), 64'd4);
    tick();

    // Depth limit: five back-to-back valids, four writes
    pulseStart();
    maxStreak = 0;
    pushExp(10'd0, 32'hFFF00093);
    pushExp(10'd4, 32'hFFF00093);
    pushExp(10'd8, 32'hFFF00093);
    pushExp(10'd12, 32'hFFF00093);
    setReq(3'd4, 4'd0, 5'd1, 5'd0, 5'd0, 13'h1FFF);
    bus.req_valid_i = 1'b1;
    repeat (5) tick();
    bus.req_valid_i = 1'b0;
    tick();
    checkEq("t3_streak", 64'(maxStreak), 64'd4);
    checkEq("t3_count", 64'(count), 64'd4);
    checkEq("t3_done", 64'(done), 64'd1);
    checkEq("t3_ready", 64'(bus.req_ready_o), 64'd0);

    // Illegal class between legal requests
    pulseStart();
    pushExp(10'd0, 32'h002081B3);
    sendReq(3'd0, 4'b0000, 5'd3, 5'd1, 5'd2, 13'd0);
    sendReq(3'd7, 4'd0, 5'd3, 5'd1, 5'd2, 13'd0);
    checkEq("t4_err_set", 64'(err), 64'd1);
    checkEq("t4_count_held", 64'(count), 64'd1);
    pushExp(10'd4, 32'h402081B3);
    sendReq(3'd0, 4'b1000, 5'd3, 5'd1, 5'd2, 13'd0);
    tick();
    checkEq("t4_err_sticky", 64'(err), 64'd1);
    checkEq("t4_count", 64'(count), 64'd2);
    pulseFinish();
    pulseStart();
    checkEq("t4_err_clr", 64'(err), 64'd0);

    // finish with a handshake in the same cycle
    pushExp(10'd0, 32'h00813283);
    finish = 1'b1;
    sendReq(3'd1, 4'd0, 5'd5, 5'd2, 5'd0, 13'd8);
    finish = 1'b0;
    checkEq("t5_we", 64'(bus.we_o), 64'd1);
    checkEq("t5_done", 64'(done), 64'd1);
    checkEq("t5_ready", 64'(bus.req_ready_o), 64'd0);
    checkEq("t5_count", 64'(count), 64'd1);
    // Requests while DONE are ignored
    sendReq(3'd4, 4'd0, 5'd1, 5'd0, 5'd0, 13'h1FFF);
    tick();
    checkEq("t5_ignored", 64'(count), 64'd1);

    // Reset right after a handshake drops the pending write
    pulseStart();
    setReq(3'd4, 4'd0, 5'd1, 5'd0, 5'd0, 13'h1FFF);
    bus.req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    rstN = 1'b0;
    #1;
    checkEq("t6_we", 64'(bus.we_o), 64'd0);
    checkEq("t6_waddr", 64'(bus.waddr_o), 64'd0);
    checkEq("t6_wdata", 64'(bus.wdata_o), 64'd0);
    checkEq("t6_count", 64'(count), 64'd0);
    checkEq("t6_done", 64'(done), 64'd0);
    checkEq("t6_ready", 64'(bus.req_ready_o), 64'd0);
    @(negedge clk);
    checkEq("t6_we_neg", 64'(bus.we_o), 64'd0);
    tick();
    rstN = 1'b1;
    tick();
    tick();

    checkEq("sb_drained", 64'(expQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
